// File: rtl/felica_resp_sched.sv
// FeliCa / NFC Type 3 response scheduler.
// After a reader frame ends, waits the slot delay, then sends a Manchester-coded
// 48-bit zero preamble, the 0xB24D sync word and the ARM-supplied payload bytes
// on mod_out. Payload bytes arrive through a one-byte holding register.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | disabled, everything flushed
// ARMED    | waiting for frame_end, first payload byte may be prefetched
// DELAY    | counting down the slot delay
// PREAMBLE | sending zero bits
// SYNC     | sending 0xB24D, MSB first
// DATA     | sending payload bytes, MSB first
module felica_resp_sched #(
  parameter int DELAY_TICKS   = 32768,
  parameter int SLOT_TICKS    = 16384,
  parameter int PREAMBLE_BITS = 48
) (
  input  logic       adc_clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       speed,
  input  logic       frame_end,
  input  logic [3:0] slot_num,
  input  logic [7:0] tx_len,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       mod_out,
  output logic       busy,
  output logic       done,
  output logic       err_underrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_DELAY, S_PREAMBLE, S_SYNC, S_DATA
  } state_t;

  localparam logic [5:0]  PRE_LAST  = 6'(PREAMBLE_BITS - 1);
  localparam logic [15:0] SYNC_WORD = 16'hB24D;

  state_t      state_q, state_d;
  logic [19:0] delay_q, delay_d;
  logic [5:0]  tick_q, tick_d;
  logic [5:0]  bit_q, bit_d;
  logic [7:0]  byte_q, byte_d;
  logic [15:0] shreg_q, shreg_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic [7:0]  acc_q, acc_d;
  logic        speed_q, speed_d;
  logic [7:0]  len_q, len_d;
  logic        mod_q, mod_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [5:0]  last_tick, half;
  logic [7:0]  limit;
  logic        bit_end, accept, load, next_byte, active_d, flush;

  // Bit timing and handshake terms derived from the registered state.
  assign last_tick = speed_q ? 6'd31 : 6'd63;
  assign half      = speed_q ? 6'd16 : 6'd32;
  assign bit_end   = (tick_q == last_tick);
  assign limit     = (state_q == S_ARMED) ? tx_len : len_q;
  assign tx_ready  = (state_q != S_IDLE) && !hold_full_q && (acc_q < limit);
  assign accept    = tx_valid && tx_ready;
  assign busy      = (state_q != S_IDLE) && (state_q != S_ARMED);

  assign mod_out      = mod_q;
  assign done         = done_q;
  assign err_underrun = err_q;

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d     = state_q;
    delay_d     = delay_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    byte_d      = byte_q;
    shreg_d     = shreg_q;
    speed_d     = speed_q;
    len_d       = len_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    acc_d       = acc_q;
    mod_d       = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    load        = 1'b0;
    next_byte   = 1'b0;
    active_d    = 1'b0;
    flush       = 1'b0;

    case (state_q)
      S_IDLE: if (enable) state_d = S_ARMED;
      S_ARMED, S_DELAY: begin
        // A new frame_end in DELAY restarts the wait with the new values.
        if (frame_end) begin
          state_d = S_DELAY;
          speed_d = speed;
          len_d   = tx_len;
          delay_d = 20'(DELAY_TICKS - 1 + int'(slot_num) * SLOT_TICKS);
          tick_d  = 6'd0;
          bit_d   = 6'd0;
          byte_d  = 8'd0;
        end else if (state_q == S_DELAY) begin
          if (delay_q == 20'd0) begin
            state_d = S_PREAMBLE;
            tick_d  = 6'd0;
            bit_d   = 6'd0;
            shreg_d = 16'd0;
          end else begin
            delay_d = delay_q - 20'd1;
          end
        end
      end
      S_PREAMBLE, S_SYNC, S_DATA: begin
        tick_d = bit_end ? 6'd0 : tick_q + 6'd1;
        if (bit_end) begin
          if (state_q == S_PREAMBLE) begin
            if (bit_q == PRE_LAST) begin
              state_d = S_SYNC;
              bit_d   = 6'd0;
              shreg_d = SYNC_WORD;
            end else begin
              bit_d = bit_q + 6'd1;
            end
          end else if (bit_q == ((state_q == S_SYNC) ? 6'd15 : 6'd7)) begin
            if (state_q == S_SYNC) begin
              byte_d = 8'd0;
              if (len_q == 8'd0) begin
                state_d = S_ARMED;
                done_d  = 1'b1;
              end else begin
                next_byte = 1'b1;
              end
            end else begin
              byte_d = byte_q + 8'd1;
              if (byte_q + 8'd1 == len_q) begin
                state_d = S_ARMED;
                done_d  = 1'b1;
              end else begin
                next_byte = 1'b1;
              end
            end
          end else begin
            bit_d   = bit_q + 6'd1;
            shreg_d = {shreg_q[14:0], 1'b0};
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Byte boundary: take the next payload byte or abort on underrun.
    if (next_byte) begin
      if (hold_full_q) begin
        state_d = S_DATA;
        load    = 1'b1;
        shreg_d = {hold_q, 8'h00};
        bit_d   = 6'd0;
      end else begin
        state_d = S_ARMED;
        err_d   = 1'b1;
      end
    end

    if (!enable) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end

    active_d = (state_d == S_PREAMBLE) || (state_d == S_SYNC) || (state_d == S_DATA);
    if (!active_d) tick_d = 6'd0;

    // Leaving a transaction (or disabling) discards any pending byte.
    flush       = (state_d == S_IDLE) || ((state_d == S_ARMED) && (state_q != S_ARMED));
    hold_full_d = flush ? 1'b0 : (accept || (hold_full_q && !load));
    if (accept) hold_d = tx_data;
    acc_d = flush ? 8'd0 : acc_q + {7'd0, accept};

    // Registered Manchester output aligned with the tick being entered.
    mod_d = active_d && (shreg_d[15] ^ (tick_d >= half));
  end

  // State and datapath registers.
  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      delay_q     <= 20'd0;
      tick_q      <= 6'd0;
      bit_q       <= 6'd0;
      byte_q      <= 8'd0;
      shreg_q     <= 16'd0;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
      acc_q       <= 8'd0;
      speed_q     <= 1'b0;
      len_q       <= 8'd0;
      mod_q       <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      delay_q     <= delay_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      byte_q      <= byte_d;
      shreg_q     <= shreg_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      acc_q       <= acc_d;
      speed_q     <= speed_d;
      len_q       <= len_d;
      mod_q       <= mod_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: doc/felica_resp_sched.md
Name: felica_resp_sched

Overview:
- Response scheduler for the ISO/IEC 18092 (FeliCa / NFC Type 3) tag-emulation path.
- After the demodulator reports end of a reader frame, waits the time-slot delay for the selected slot, then drives the load-modulation enable.
- Output sequence, Manchester-coded at 212 or 424 kbit/s: 48-bit preamble, then 0xB24D sync, then ARM-supplied payload bytes.
- Sits between the 18092 demodulator, the SSP byte path from the ARM, and the pwr_oe4 modulation driver.

Parameters:
- DELAY_TICKS, 32768: carrier ticks (fc) from frame_end to slot 0 start (512*64/fc).
- SLOT_TICKS, 16384: carrier ticks per additional slot (256*64/fc).
- PREAMBLE_BITS, 48: number of zero bits sent before sync.

Ports:
- adc_clk, in, 1: fc (13.56 MHz) clock; all logic on posedge.
- rst_n, in, 1: asynchronous active-low reset.
- enable, in, 1: arm the scheduler; 0 forces IDLE.
- speed, in, 1: 0 = 212 kbit/s (64 ticks/bit), 1 = 424 kbit/s (32 ticks/bit); latched on frame_end.
- frame_end, in, 1: single-cycle pulse from the demodulator at end of a reader frame.
- slot_num, in, 4: response slot 0..15; latched on frame_end.
- tx_len, in, 8: payload byte count 0..255; latched on frame_end.
- tx_data, in, 8: payload byte from the ARM, sent MSB first.
- tx_valid, in, 1: tx_data valid.
- tx_ready, out, 1: holding register empty; transfer happens when tx_valid && tx_ready.
- mod_out, out, 1: load-modulation enable to the driver.
- busy, out, 1: high in every state except IDLE and ARMED.
- done, out, 1: one-cycle pulse when the last payload bit completes.
- err_underrun, out, 1: one-cycle pulse when a payload byte is needed and the holding register is empty.

Behaviour:
- Reset (async assert, sync release): state IDLE, mod_out=0, tx_ready=0, busy=0, done=0, err_underrun=0; all counters and registers cleared.
- States: IDLE, ARMED, DELAY, PREAMBLE, SYNC, DATA.
- Transitions:
  - IDLE -> ARMED when enable=1.
  - ARMED -> DELAY on frame_end. Same cycle: latch speed/slot_num/tx_len; load the 20-bit delay counter with DELAY_TICKS + slot_num*SLOT_TICKS - 1.
  - DELAY: decrement each cycle; at 0 go to PREAMBLE.
  - PREAMBLE -> SYNC after PREAMBLE_BITS bits.
  - SYNC -> DATA after 16 bits; if latched tx_len=0, go straight to ARMED with a done pulse.
  - DATA -> ARMED after tx_len*8 bits, with a done pulse on the cycle the last bit period ends.
- enable=0 in any state: IDLE on the next edge; mod_out=0 from that edge; holding register flushed.
- frame_end during DELAY: restart the delay from the newly latched values (the reader sent another frame).
- frame_end during PREAMBLE, SYNC or DATA: ignored.
- Bit timing:
  - Tick counter runs 0..BITLEN-1, where BITLEN = 64 or 32.
  - Bit boundary at count BITLEN-1; the first bit starts on the cycle after the DELAY counter reaches 0.
- Manchester encoding (registered):
  - mod_out = bit during the first half (count < BITLEN/2); mod_out = ~bit during the second half.
  - Preamble bits are 0. Sync is 0xB24D, MSB first.
- Payload shift register:
  - Loaded from the holding register at the boundary entering each payload byte, including the SYNC->DATA boundary.
  - If the holding register is empty at that boundary: pulse err_underrun, go to ARMED, mod_out=0.
- tx_ready:
  - High when the holding register is empty, state is not IDLE, and fewer than tx_len bytes have been accepted.
  - Accepting is allowed from ARMED onward, so the first byte is prefetched before transmission.
  - A load and a new accept in the same cycle are allowed; the holding register ends up full.
- Accepted byte counter: 8 bits, no wrap; once it equals the latched tx_len, tx_ready stays 0.
- In ARMED and DELAY, tx_len for the accept limit is the live input until frame_end, then the latched value.
- mod_out=0 in IDLE, ARMED and DELAY.
- done and err_underrun are never asserted in the same cycle.

Test Plan:
- Reset mid-DATA at 212 kbit/s: assert rst_n=0 -> mod_out, busy, tx_ready go 0 immediately; state IDLE after release.
- speed=0, slot_num=0, tx_len=2, bytes 0xA5 and 0x3C prefetched, frame_end:
  - first mod_out rise from a preamble bit exactly 32768+32 cycles after frame_end (second half of bit 0);
  - sync 0xB24D waveform matches at 64-tick bits;
  - payload 0xA5, 0x3C follow;
  - done pulses 64*(48+16+16) cycles after slot start.
- speed=1, slot_num=3, tx_len=0: slot start at 32768+3*16384 cycles; 64 bits of 32 ticks; done at 2048 cycles after slot start; tx_ready never asserted.
- tx_len=3, only two bytes supplied: err_underrun pulses at the start of the third byte (slot start + 64*(64+16) ticks at 212); mod_out=0 thereafter; state ARMED.
- Second frame_end 1000 cycles into DELAY: slot start measured from the second pulse (32768 cycles later).
- enable dropped during SYNC: mod_out=0 and busy=0 on the next edge; tx_ready=0; a later frame_end is ignored until enable=1.
